// File: rtl/imem_fetch_arbiter.sv
// Shares one byte-wide memory read port between instruction fetch (IF) and the
// debug/data port (DP), assembling little-endian 32-bit words over four reads.
module imem_fetch_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_req,
  input  logic [ADDRESS_WIDTH-1:0]  if_addr,
  output logic                      if_ack,
  input  logic                      dp_req,
  input  logic [ADDRESS_WIDTH-1:0]  dp_addr,
  output logic                      dp_ack,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]                mem_rd,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      busy,
  output logic                      gnt_id
);

  // Handshake: a requester raises req with a stable addr and holds it until
  // its ack; ack is a one-cycle pulse in RESP with rdata valid that cycle.
  // Dropping req early does not cancel a granted transaction.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [1:0]                cnt;
  logic [MEM_ADDR_WIDTH-1:0] base;
  logic                      last_dp;
  logic [DATA_WIDTH-9:0]     lanes;
  logic                      any_req;
  logic                      grant_dp;

  // Only the low MEM_ADDR_WIDTH address bits select a byte in the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH],
                              dp_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH]};

  // On a tie, the requester not granted last wins; last_dp resets to DP.
  always_comb begin
    any_req  = if_req | dp_req;
    grant_dp = dp_req & (~if_req | ~last_dp);
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    if_ack    = 1'b0;
    dp_ack    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = READ;
      end
      READ: begin
        busy     = 1'b1;
        mem_addr = base + MEM_ADDR_WIDTH'(cnt);
        if (cnt == 2'd3) state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        if_ack    = ~gnt_id;
        dp_ack    = gnt_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      base    <= '0;
      last_dp <= 1'b1;
      gnt_id  <= 1'b0;
      lanes   <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            base    <= grant_dp ? dp_addr[MEM_ADDR_WIDTH-1:0] : if_addr[MEM_ADDR_WIDTH-1:0];
            gnt_id  <= grant_dp;
            last_dp <= grant_dp;
            cnt     <= 2'd0;
          end
        end
        READ: begin
          case (cnt)
            2'd0: lanes[7:0]   <= mem_rd;
            2'd1: lanes[15:8]  <= mem_rd;
            2'd2: lanes[23:16] <= mem_rd;
            default: rdata     <= {mem_rd, lanes};
          endcase
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a 256-byte combinational memory
// model; inputs are driven and outputs sampled on the falling clock edge.
module tb_imem_fetch_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        dp_req;
  logic [31:0] dp_addr;
  logic        dp_ack;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rd;
  logic [31:0] rdata;
  logic        busy;
  logic        gnt_id;

  logic [7:0] mem [256];
  int checks;
  int errors;

  imem_fetch_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .dp_req   (dp_req),
    .dp_addr  (dp_addr),
    .dp_ack   (dp_ack),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .rdata    (rdata),
    .busy     (busy),
    .gnt_id   (gnt_id)
  );

  assign mem_rd = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0; if_req = 1'b0; dp_req = 1'b0; if_addr = '0; dp_addr = '0;
    repeat (2) @(negedge clk);
    checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL reset_if_ack: got %b exp 0", if_ack); end
    checks++; if (dp_ack !== 1'b0) begin errors++; $display("FAIL reset_dp_ack: got %b exp 0", dp_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (gnt_id !== 1'b0) begin errors++; $display("FAIL reset_gnt_id: got %b exp 0", gnt_id); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h exp 00", mem_addr); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 00000000", rdata); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_single_fetch;
    int lat;
    int na;
    logic [7:0] addrs [4];
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h50; mem[3] = 8'h00;
    if_addr = 32'h0; if_req = 1'b1;
    lat = 0; na = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); lat = c;
      if (if_ack || dp_ack) break;
      if (busy && na < 4) begin addrs[na] = mem_addr; na++; end
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL single_latency: got %0d exp 5", lat); end
    checks++; if (if_ack !== 1'b1) begin errors++; $display("FAIL single_if_ack: got %b exp 1", if_ack); end
    checks++; if (dp_ack !== 1'b0) begin errors++; $display("FAIL single_dp_ack: got %b exp 0", dp_ack); end
    checks++; if (rdata !== 32'h00500513) begin errors++; $display("FAIL single_rdata: got %h exp 00500513", rdata); end
    checks++; if (gnt_id !== 1'b0) begin errors++; $display("FAIL single_gnt_id: got %b exp 0", gnt_id); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (na != 4 || addrs[i] !== 8'(i)) begin errors++; $display("FAIL single_mem_addr%0d: got %h exp %h", i, addrs[i], 8'(i)); end
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL single_ack_width: got %b exp 0", if_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_back_idle: got %b exp 0", busy); end
    checks++; if (rdata !== 32'h00500513) begin errors++; $display("FAIL single_rdata_hold: got %h exp 00500513", rdata); end
  endtask

  task automatic test_wrap;
    int lat;
    int na;
    logic [7:0] addrs [4];
    logic [7:0] exp_a [4];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC; mem[8'h01] = 8'hDD;
    dp_addr = 32'hFE; dp_req = 1'b1;
    lat = 0; na = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); lat = c;
      if (if_ack || dp_ack) break;
      if (busy && na < 4) begin addrs[na] = mem_addr; na++; end
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL wrap_latency: got %0d exp 5", lat); end
    checks++; if (dp_ack !== 1'b1) begin errors++; $display("FAIL wrap_dp_ack: got %b exp 1", dp_ack); end
    checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL wrap_if_ack: got %b exp 0", if_ack); end
    checks++; if (gnt_id !== 1'b1) begin errors++; $display("FAIL wrap_gnt_id: got %b exp 1", gnt_id); end
    checks++; if (rdata !== 32'hDDCCBBAA) begin errors++; $display("FAIL wrap_rdata: got %h exp ddccbbaa", rdata); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (na != 4 || addrs[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_mem_addr%0d: got %h exp %h", i, addrs[i], exp_a[i]); end
    end
    dp_req = 1'b0;
    @(negedge clk);
    checks++; if (dp_ack !== 1'b0) begin errors++; $display("FAIL wrap_ack_width: got %b exp 0", dp_ack); end
  endtask

  task automatic test_round_robin;
    int gap;
    logic exp_dp;
    logic [31:0] exp_w;
    mem[8'h08] = 8'h01; mem[8'h09] = 8'h02; mem[8'h0A] = 8'h03; mem[8'h0B] = 8'h04;
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
    rst_n = 1'b0;
    if_addr = 32'h08; dp_addr = 32'h10; if_req = 1'b1; dp_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_dp = g[0];
      exp_w  = exp_dp ? 32'hD4C3B2A1 : 32'h04030201;
      gap = 0;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk); gap = c;
        if (if_ack || dp_ack) break;
      end
      checks++; if (gap !== (g == 0 ? 5 : 6)) begin errors++; $display("FAIL rr_gap%0d: got %0d exp %0d", g, gap, (g == 0 ? 5 : 6)); end
      checks++; if (gnt_id !== exp_dp) begin errors++; $display("FAIL rr_gnt_id%0d: got %b exp %b", g, gnt_id, exp_dp); end
      checks++; if ({if_ack, dp_ack} !== {~exp_dp, exp_dp}) begin errors++; $display("FAIL rr_acks%0d: got %b%b exp %b%b", g, if_ack, dp_ack, ~exp_dp, exp_dp); end
      checks++; if (rdata !== exp_w) begin errors++; $display("FAIL rr_rdata%0d: got %h exp %h", g, rdata, exp_w); end
    end
    if_req = 1'b0; dp_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b exp 0", busy); end
  endtask

  task automatic test_upper_bits;
    int lat;
    logic [31:0] addr_tab [2];
    logic [31:0] word_tab [2];
    addr_tab[0] = 32'h1000_0004; word_tab[0] = 32'h44332211;
    addr_tab[1] = 32'h0000_0005; word_tab[1] = 32'h55443322;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44; mem[8] = 8'h55;
    for (int t = 0; t < 2; t++) begin
      if_addr = addr_tab[t]; if_req = 1'b1;
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk); lat = c;
        if (if_ack || dp_ack) break;
      end
      checks++; if (lat !== 5) begin errors++; $display("FAIL upper_latency%0d: got %0d exp 5", t, lat); end
      checks++; if (if_ack !== 1'b1) begin errors++; $display("FAIL upper_if_ack%0d: got %b exp 1", t, if_ack); end
      checks++; if (rdata !== word_tab[t]) begin errors++; $display("FAIL upper_rdata%0d: got %h exp %h", t, rdata, word_tab[t]); end
      if_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_read;
    int lat;
    int acks;
    if_addr = 32'h04; if_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (mem_addr !== 8'h06) begin errors++; $display("FAIL midrst_pre_addr: got %h exp 06", mem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b exp 0", busy); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL midrst_mem_addr: got %h exp 00", mem_addr); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h exp 00000000", rdata); end
    checks++; if (gnt_id !== 1'b0) begin errors++; $display("FAIL midrst_gnt_id: got %b exp 0", gnt_id); end
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (if_ack || dp_ack) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL midrst_no_ack: got %0d exp 0", acks); end
    rst_n = 1'b1;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); lat = c;
      if (if_ack || dp_ack) break;
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_restart_latency: got %0d exp 5", lat); end
    checks++; if (if_ack !== 1'b1) begin errors++; $display("FAIL midrst_restart_ack: got %b exp 1", if_ack); end
    checks++; if (rdata !== 32'h44332211) begin errors++; $display("FAIL midrst_restart_rdata: got %h exp 44332211", rdata); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_early_drop;
    int if_acks;
    int dp_acks;
    int ack_at;
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h50; mem[3] = 8'h00;
    if_addr = 32'h0; if_req = 1'b1;
    @(negedge clk);
    if_req = 1'b0;
    if_acks = 0; dp_acks = 0; ack_at = 0;
    for (int c = 2; c <= 14; c++) begin
      @(negedge clk);
      if (if_ack) begin if_acks++; ack_at = c; end
      if (dp_ack) dp_acks++;
    end
    checks++; if (if_acks !== 1) begin errors++; $display("FAIL drop_if_ack_count: got %0d exp 1", if_acks); end
    checks++; if (ack_at !== 5) begin errors++; $display("FAIL drop_ack_cycle: got %0d exp 5", ack_at); end
    checks++; if (dp_acks !== 0) begin errors++; $display("FAIL drop_dp_ack_count: got %0d exp 0", dp_acks); end
    checks++; if (rdata !== 32'h00500513) begin errors++; $display("FAIL drop_rdata: got %h exp 00500513", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b exp 0", busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_single_fetch();
    test_wrap();
    test_round_robin();
    test_upper_bits();
    test_reset_mid_read();
    test_early_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
